// File: rtl/apb_master_arbiter.sv
// APB master shared by NUM_REQ local requesters via round-robin arbitration.
// Ports: PCLK/PRESETn (sync active-low); req_* request side with one-hot
// req_ready accept; rsp_* one-hot completion with rdata/err; P* APB master bus.
module apb_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    gnt_q, gnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                gnt_any;
  logic [IDX_W-1:0]    gnt_idx;
  logic                tmo_hit;
  logic                xfer_end;
  logic [IDX_W-1:0]    rr_next;

  // Scan downward over offsets so the smallest offset from rr_ptr wins.
  always_comb begin : p_arb
    int cand;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req_valid[IDX_W'(cand)]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

  assign tmo_hit  = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign xfer_end = (state_q == S_ACCESS) && (PREADY || tmo_hit);
  assign rr_next  = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;

  // State and datapath registers
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (gnt_any) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (xfer_end) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath next values
  always_comb begin
    req_ready   = '0;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          if (PRESETn) req_ready[gnt_idx] = 1'b1;
          gnt_d    = gnt_idx;
          cnt_d    = '0;
          psel_d   = 1'b1;
          pwrite_d = req_write[gnt_idx];
          paddr_d  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
          pwdata_d = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
        end
      end
      S_SETUP: penable_d = 1'b1;
      S_ACCESS: begin
        if (xfer_end) begin
          rsp_valid_d[gnt_q] = 1'b1;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rr_ptr_d  = rr_next;
          // PREADY on the final wait cycle still counts as a real completion
          if (PREADY) begin
            rsp_err_d   = PSLVERR;
            rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          end else begin
            rsp_err_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
